// File: rtl/multicycle_control_unit_pkg.sv
// ============================================================================
// Module : multicycle_control_unit_pkg
// Brief  : Shared datapath select types, opcodes, trap causes and decode helpers
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multicycle_control_unit_pkg;

   typedef struct packed {
      logic [6:0] funct7;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [4:0] rd;
      logic [6:0] opcode;
   } ir_R_t;

   typedef enum logic [1:0] {
      PCSEL_PC    = 2'd0,
      PCSEL_PLUS4 = 2'd1,
      PCSEL_ALU   = 2'd2,
      PCSEL_TRAP  = 2'd3
   } pcsel_t;

   typedef enum logic {IRSEL_IR = 1'b0, IRSEL_MEM = 1'b1} irsel_t;

   typedef enum logic [1:0] {
      REGSEL_ALU   = 2'd0,
      REGSEL_MEM   = 2'd1,
      REGSEL_PLUS4 = 2'd2,
      REGSEL_RSV   = 2'd3
   } regsel_t;

   typedef enum logic {ALUSEL0_RS1  = 1'b0, ALUSEL0_PC   = 1'b1} alusel0_t;
   typedef enum logic {ALUSEL1_RS2  = 1'b0, ALUSEL1_IMM  = 1'b1} alusel1_t;
   typedef enum logic {ADDRSEL_PC   = 1'b0, ADDRSEL_ALU  = 1'b1} addrsel_t;
   typedef enum logic {RS1SEL_RS1   = 1'b0, RS1SEL_RSD   = 1'b1} rs1sel_t;
   typedef enum logic {TMPSEL_BYTE  = 1'b0, TMPSEL_HALF  = 1'b1} tmpsel_t;
   typedef enum logic {DATAOUTSEL_REG = 1'b0, DATAOUTSEL_TMP = 1'b1} dataoutsel_t;

   // ALU operation is {funct3, funct7}; OP_PASSB forwards operand B (LUI)
   typedef logic [9:0] operation_t;
   localparam operation_t OP_ADD   = 10'b000_0000000;
   localparam operation_t OP_PASSB = 10'b000_1111111;

   typedef enum logic [3:0] {
      CAUSE_NONE        = 4'd0,
      CAUSE_ILLEGAL     = 4'd2,
      CAUSE_LD_MISALIGN = 4'd4,
      CAUSE_MEM_TIMEOUT = 4'd5,
      CAUSE_ST_MISALIGN = 4'd6
   } cause_t;

   localparam logic [31:0] TRAP_VECTOR = 32'h0000_0100;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   function automatic logic is_legal(input logic [6:0] opcode, input logic [2:0] f3);
      case (opcode)
         OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_JAL: return 1'b1;
         OPC_JALR:   return (f3 == 3'b000);
         OPC_BRANCH: return (f3[2:1] != 2'b01);
         OPC_LOAD:   return (f3 != 3'b011) && (f3[2:1] != 2'b11);
         OPC_STORE:  return (f3[2] == 1'b0) && (f3[1:0] != 2'b11);
         default:    return 1'b0;
      endcase
   endfunction

   // funct3[0] inverts the base compare (BNE/BGE/BGEU)
   function automatic logic branch_taken(input logic [2:0] f3, input logic altb,
                                         input logic aeqb);
      case (f3[2:1])
         2'b00:        return aeqb ^ f3[0];
         2'b10, 2'b11: return altb ^ f3[0];
         default:      return 1'b0;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_control_unit_mem_wait_timer.sv
// ============================================================================
// Module : mem_wait_timer
// Brief  : Counts cycles spent waiting on mem_ready and flags a watchdog timeout
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   input  logic i_waiting,
   output logic o_timeout
);

   generate
      if (MEM_TIMEOUT > 0) begin : g_watchdog
         localparam int CW = $clog2(MEM_TIMEOUT + 1);
         localparam logic [CW-1:0] C_LIMIT = CW'(MEM_TIMEOUT);
         logic [CW-1:0] r_count;

         always_ff @(posedge i_clk) begin
            if (i_rst || i_clear) begin
               r_count <= '0;
            end else if (i_waiting && (r_count != C_LIMIT)) begin
               r_count <= r_count + 1'b1;
            end
         end

         assign o_timeout = (r_count == C_LIMIT);
      end else begin : g_no_watchdog
         logic w_unused;
         assign w_unused  = &{1'b0, i_clk, i_rst, i_clear, i_waiting};
         assign o_timeout = 1'b0;
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
// ============================================================================
// Module : multicycle_control_unit
// Brief  : RV32I multicycle controller with ready handshake, watchdog and traps.
//          Define MISALIGN_TRAP_EN to trap misaligned loads/stores.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control_unit
   import multicycle_control_unit_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic [31:0]      i_ir,
   input  logic             i_altb,
   input  logic             i_aeqb,
   input  logic             i_mem_ready,
   input  logic [1:0]       i_addr_lo,
   output logic [1:0]       o_pcsel,
   output logic             o_irsel,
   output logic [1:0]       o_regsel,
   output logic             o_regen,
   output logic             o_alusel0,
   output logic             o_alusel1,
   output logic [9:0]       o_op,
   output logic             o_re,
   output logic             o_we,
   output logic             o_addrsel,
   output logic             o_rs1sel,
   output logic             o_tmpsel,
   output logic             o_dataoutsel,
   output logic             o_un_signed,
   output logic             o_trap,
   output logic [3:0]       o_trap_cause,
   output logic [CNT_W-1:0] o_retired
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_EXEC   = 3'd1,
      S_MEM_RD = 3'd2,
      S_MEM_WR = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   state_t           r_state;
   cause_t           r_trap_cause;
   logic [CNT_W-1:0] r_retired;

   ir_R_t       w_ir;
   state_t      w_next;
   cause_t      w_cause;
   pcsel_t      w_pcsel;
   irsel_t      w_irsel;
   regsel_t     w_regsel;
   alusel0_t    w_alusel0;
   alusel1_t    w_alusel1;
   operation_t  w_alu_op;
   operation_t  w_op;
   addrsel_t    w_addrsel;
   rs1sel_t     w_rs1sel;
   tmpsel_t     w_tmpsel;
   dataoutsel_t w_dataoutsel;
   logic        w_regen, w_re, w_we, w_un_signed, w_trap;
   logic        w_access, w_waiting, w_timeout, w_misalign, w_retire, w_unused;

   assign w_ir = i_ir;

`ifdef MISALIGN_TRAP_EN
   assign w_misalign = ((w_ir.funct3[1:0] == 2'b01) && i_addr_lo[0]) ||
                       ((w_ir.funct3[1:0] == 2'b10) && (i_addr_lo != 2'b00));
   assign w_unused   = &{1'b0, w_ir.rd, w_ir.rs1, w_ir.rs2};
`else
   assign w_misalign = 1'b0;
   assign w_unused   = &{1'b0, w_ir.rd, w_ir.rs1, w_ir.rs2, i_addr_lo};
`endif

   assign w_access  = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
   assign w_waiting = w_access && !i_mem_ready;

   mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_mem_wait_timer (
      .i_clk     (i_clock),
      .i_rst     (i_reset),
      .i_clear   (w_next != r_state),
      .i_waiting (w_waiting),
      .o_timeout (w_timeout)
   );

   // ALU operand decode depends only on ir, so it stays stable across memory waits
   always_comb begin
      w_alusel0 = ALUSEL0_RS1;
      w_alusel1 = ALUSEL1_IMM;
      w_alu_op  = OP_ADD;
      case (w_ir.opcode)
         OPC_OP: begin
            w_alusel1 = ALUSEL1_RS2;
            w_alu_op  = {w_ir.funct3, w_ir.funct7};
         end
         OPC_OPIMM: w_alu_op = {w_ir.funct3, (w_ir.funct3[1:0] == 2'b01) ? w_ir.funct7 : 7'd0};
         OPC_LUI:   w_alu_op = OP_PASSB;
         OPC_AUIPC, OPC_BRANCH, OPC_JAL: w_alusel0 = ALUSEL0_PC;
         default: ;
      endcase
   end

   always_comb begin
      w_pcsel      = PCSEL_PC;
      w_irsel      = IRSEL_IR;
      w_regsel     = REGSEL_ALU;
      w_regen      = 1'b0;
      w_op         = w_alu_op;
      w_re         = 1'b0;
      w_we         = 1'b0;
      w_addrsel    = ADDRSEL_PC;
      w_rs1sel     = RS1SEL_RS1;
      w_tmpsel     = tmpsel_t'(w_ir.funct3[0]);
      w_dataoutsel = (w_ir.funct3[1:0] == 2'b10) ? DATAOUTSEL_REG : DATAOUTSEL_TMP;
      w_un_signed  = (w_ir.opcode == OPC_BRANCH) && (w_ir.funct3[2:1] == 2'b11);
      w_trap       = 1'b0;
      w_next       = r_state;
      w_cause      = CAUSE_NONE;
      case (r_state)
         S_FETCH: begin
            w_re = 1'b1;
            if (i_mem_ready) begin
               w_irsel = IRSEL_MEM;
               w_pcsel = PCSEL_PLUS4;
               w_next  = S_EXEC;
            end
         end
         S_EXEC: begin
            if (!is_legal(w_ir.opcode, w_ir.funct3)) begin
               w_next  = S_TRAP;
               w_cause = CAUSE_ILLEGAL;
            end else begin
               case (w_ir.opcode)
                  OPC_BRANCH: begin
                     if (branch_taken(w_ir.funct3, i_altb, i_aeqb)) w_pcsel = PCSEL_ALU;
                     w_next = S_FETCH;
                  end
                  OPC_JAL, OPC_JALR: begin
                     w_regsel = REGSEL_PLUS4;
                     w_regen  = 1'b1;
                     w_pcsel  = PCSEL_ALU;
                     w_next   = S_FETCH;
                  end
                  OPC_LOAD: begin
                     w_next  = w_misalign ? S_TRAP : S_MEM_RD;
                     w_cause = w_misalign ? CAUSE_LD_MISALIGN : CAUSE_NONE;
                  end
                  OPC_STORE: begin
                     if (w_misalign) begin
                        w_next  = S_TRAP;
                        w_cause = CAUSE_ST_MISALIGN;
                     end else begin
                        // SB/SH need a merge read of the target word first
                        w_next = (w_ir.funct3[1:0] == 2'b10) ? S_MEM_WR : S_MEM_RD;
                     end
                  end
                  default: begin
                     w_regen = 1'b1;
                     w_next  = S_FETCH;
                  end
               endcase
            end
         end
         S_MEM_RD: begin
            w_re      = 1'b1;
            w_addrsel = ADDRSEL_ALU;
            w_op      = OP_ADD;
            if (i_mem_ready) begin
               if (w_ir.opcode == OPC_STORE) begin
                  w_next = S_MEM_WR;
               end else begin
                  w_regsel = REGSEL_MEM;
                  w_regen  = 1'b1;
                  w_next   = S_WB;
               end
            end
         end
         S_MEM_WR: begin
            w_we      = 1'b1;
            w_addrsel = ADDRSEL_ALU;
            w_op      = OP_ADD;
            if (i_mem_ready) w_next = S_FETCH;
         end
         S_WB: begin
            w_rs1sel = RS1SEL_RSD;
            w_regsel = REGSEL_ALU;
            w_regen  = 1'b1;
            w_op     = {w_ir.funct3, w_ir.funct7};
            w_next   = S_FETCH;
         end
         S_TRAP: begin
            w_pcsel = PCSEL_TRAP;
            w_trap  = 1'b1;
            w_next  = S_FETCH;
         end
         default: w_next = S_FETCH;
      endcase
      // Watchdog expiry abandons the access regardless of a late ready
      if (w_timeout) begin
         w_re    = 1'b0;
         w_we    = 1'b0;
         w_pcsel = PCSEL_PC;
         w_irsel = IRSEL_IR;
         w_regen = 1'b0;
         w_next  = S_TRAP;
         w_cause = CAUSE_MEM_TIMEOUT;
      end
   end

   assign w_retire = (w_next == S_FETCH) &&
                     ((r_state == S_EXEC) || (r_state == S_MEM_WR) || (r_state == S_WB));

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state      <= S_FETCH;
         r_trap_cause <= CAUSE_NONE;
         r_retired    <= '0;
      end else begin
         r_state <= w_next;
         if (w_next == S_TRAP) r_trap_cause <= w_cause;
         if (w_retire)         r_retired    <= r_retired + CNT_W'(1);
      end
   end

   assign o_pcsel      = i_reset ? 2'b00  : w_pcsel;
   assign o_irsel      = i_reset ? 1'b0   : w_irsel;
   assign o_regsel     = i_reset ? 2'b00  : w_regsel;
   assign o_regen      = i_reset ? 1'b0   : w_regen;
   assign o_alusel0    = i_reset ? 1'b0   : w_alusel0;
   assign o_alusel1    = i_reset ? 1'b0   : w_alusel1;
   assign o_op         = i_reset ? 10'd0  : w_op;
   assign o_re         = i_reset ? 1'b0   : w_re;
   assign o_we         = i_reset ? 1'b0   : w_we;
   assign o_addrsel    = i_reset ? 1'b0   : w_addrsel;
   assign o_rs1sel     = i_reset ? 1'b0   : w_rs1sel;
   assign o_tmpsel     = i_reset ? 1'b0   : w_tmpsel;
   assign o_dataoutsel = i_reset ? 1'b0   : w_dataoutsel;
   assign o_un_signed  = i_reset ? 1'b0   : w_un_signed;
   assign o_trap       = i_reset ? 1'b0   : w_trap;
   assign o_trap_cause = i_reset ? 4'd0   : r_trap_cause;
   assign o_retired    = i_reset ? '0     : r_retired;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
// ============================================================================
// Module : tb_multicycle_control_unit
// Brief  : Directed self-checking bench for multicycle_control_unit
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control_unit;
   import multicycle_control_unit_pkg::*;

   localparam logic [31:0] C_ADD  = 32'h0020_81B3;  // add  x3,x1,x2
   localparam logic [31:0] C_LW   = 32'h0000_A283;  // lw   x5,0(x1)
   localparam logic [31:0] C_LH   = 32'h0000_9283;  // lh   x5,0(x1)
   localparam logic [31:0] C_SB   = 32'h0020_80A3;  // sb   x2,1(x1)
   localparam logic [31:0] C_SW   = 32'h0020_A023;  // sw   x2,0(x1)
   localparam logic [31:0] C_BEQ  = 32'h0020_8463;  // beq  x1,x2,8
   localparam logic [31:0] C_BLTU = 32'h0020_E463;  // bltu x1,x2,8
   localparam logic [31:0] C_JAL  = 32'h0100_00EF;  // jal  x1,16
   localparam logic [31:0] C_ILL  = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst, altb, aeqb, mem_ready;
   logic [31:0] ir;
   logic [1:0]  addr_lo;
   logic [1:0]  pcsel, regsel;
   logic        irsel, regen, alusel0, alusel1, re, we, addrsel, rs1sel, tmpsel;
   logic        dataoutsel, un_signed, trap;
   logic [9:0]  op;
   logic [3:0]  trap_cause;
   logic [31:0] retired;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   multicycle_control_unit #(
      .MEM_TIMEOUT (16),
      .CNT_W       (32)
   ) u_dut (
      .i_clock      (clk),
      .i_reset      (rst),
      .i_ir         (ir),
      .i_altb       (altb),
      .i_aeqb       (aeqb),
      .i_mem_ready  (mem_ready),
      .i_addr_lo    (addr_lo),
      .o_pcsel      (pcsel),
      .o_irsel      (irsel),
      .o_regsel     (regsel),
      .o_regen      (regen),
      .o_alusel0    (alusel0),
      .o_alusel1    (alusel1),
      .o_op         (op),
      .o_re         (re),
      .o_we         (we),
      .o_addrsel    (addrsel),
      .o_rs1sel     (rs1sel),
      .o_tmpsel     (tmpsel),
      .o_dataoutsel (dataoutsel),
      .o_un_signed  (un_signed),
      .o_trap       (trap),
      .o_trap_cause (trap_cause),
      .o_retired    (retired)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   // Called in FETCH just after an edge; returns in EXEC with ir loaded
   task automatic fetch_ok(input logic [31:0] instr);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      ir        = instr;
   endtask

   initial begin
      rst = 1'b1; ir = 32'd0; altb = 1'b0; aeqb = 1'b0; mem_ready = 1'b0; addr_lo = 2'b00;
      tick();
      tick();
      mid();
      check_eq("rst_re", re, 0);
      check_eq("rst_retired", retired, 0);
      check_eq("rst_pcsel", pcsel, 0);

      // ADD with fetch ready on the third cycle
      tick(); rst = 1'b0;
      mid();
      check_eq("f_re0", re, 1);
      check_eq("f_addrsel", addrsel, ADDRSEL_PC);
      check_eq("f_irsel_wait", irsel, IRSEL_IR);
      check_eq("f_pcsel_wait", pcsel, PCSEL_PC);
      check_eq("f_cause0", trap_cause, 0);
      tick();
      mid();
      check_eq("f_re1", re, 1);
      tick(); mem_ready = 1'b1;
      mid();
      check_eq("f_re2", re, 1);
      check_eq("f_irsel_rdy", irsel, IRSEL_MEM);
      check_eq("f_pcsel_rdy", pcsel, PCSEL_PLUS4);
      check_eq("f_regen_rdy", regen, 0);
      tick(); mem_ready = 1'b0; ir = C_ADD;
      mid();
      check_eq("add_regen", regen, 1);
      check_eq("add_regsel", regsel, REGSEL_ALU);
      check_eq("add_alusel1", alusel1, ALUSEL1_RS2);
      check_eq("add_op", op, OP_ADD);
      check_eq("add_re", re, 0);
      check_eq("add_ret_before", retired, 0);
      tick();
      mid();
      check_eq("add_ret_after", retired, 1);
      check_eq("add_regen_after", regen, 0);

      // LW whose read never completes
      fetch_ok(C_LW);
      mid();
      check_eq("lw_exec_re", re, 0);
      tick();
      for (int i = 0; i < 16; i++) begin
         mid();
         check_eq($sformatf("lwto_re%0d", i), re, 1);
         tick();
      end
      mid();
      check_eq("lwto_re_drop", re, 0);
      check_eq("lwto_regen", regen, 0);
      tick();
      mid();
      check_eq("lwto_trap", trap, 1);
      check_eq("lwto_cause", trap_cause, CAUSE_MEM_TIMEOUT);
      check_eq("lwto_pcsel", pcsel, PCSEL_TRAP);
      tick();
      mid();
      check_eq("lwto_trap_gone", trap, 0);
      check_eq("lwto_fetch_re", re, 1);
      check_eq("lwto_cause_held", trap_cause, CAUSE_MEM_TIMEOUT);
      check_eq("lwto_retired", retired, 1);

      // Illegal encoding then a normal instruction
      fetch_ok(C_ILL);
      mid();
      check_eq("ill_regen", regen, 0);
      tick();
      mid();
      check_eq("ill_trap", trap, 1);
      check_eq("ill_cause", trap_cause, CAUSE_ILLEGAL);
      check_eq("ill_retired", retired, 1);
      tick();
      mid();
      check_eq("ill_trap_once", trap, 0);
      check_eq("ill_fetch_re", re, 1);
      fetch_ok(C_ADD);
      mid();
      check_eq("ill_next_regen", regen, 1);
      tick();
      mid();
      check_eq("ill_next_retired", retired, 2);

      // SB: merge read then write, each ready after one wait cycle
      addr_lo = 2'b01;
      fetch_ok(C_SB);
      mid();
      check_eq("sb_exec_re", re, 0);
      check_eq("sb_exec_we", we, 0);
      tick();
      mid();
      check_eq("sb_rd_re", re, 1);
      check_eq("sb_rd_tmpsel", tmpsel, TMPSEL_BYTE);
      check_eq("sb_rd_addrsel", addrsel, ADDRSEL_ALU);
      tick(); mem_ready = 1'b1;
      mid();
      check_eq("sb_rd_re_rdy", re, 1);
      check_eq("sb_rd_regen", regen, 0);
      tick(); mem_ready = 1'b0;
      mid();
      check_eq("sb_wr_we", we, 1);
      check_eq("sb_wr_re", re, 0);
      check_eq("sb_wr_dsel", dataoutsel, DATAOUTSEL_TMP);
      tick(); mem_ready = 1'b1;
      mid();
      check_eq("sb_wr_we_rdy", we, 1);
      tick(); mem_ready = 1'b0; addr_lo = 2'b00;
      mid();
      check_eq("sb_retired", retired, 3);

      // Branches
      aeqb = 1'b1;
      fetch_ok(C_BEQ);
      mid();
      check_eq("beq_t_pcsel", pcsel, PCSEL_ALU);
      check_eq("beq_t_regen", regen, 0);
      check_eq("beq_t_alusel0", alusel0, ALUSEL0_PC);
      check_eq("beq_t_unsigned", un_signed, 0);
      tick(); aeqb = 1'b0;
      fetch_ok(C_BEQ);
      mid();
      check_eq("beq_nt_pcsel", pcsel, PCSEL_PC);
      check_eq("beq_nt_regen", regen, 0);
      tick(); altb = 1'b1;
      fetch_ok(C_BLTU);
      mid();
      check_eq("bltu_pcsel", pcsel, PCSEL_ALU);
      check_eq("bltu_unsigned", un_signed, 1);
      tick(); altb = 1'b0;
      mid();
      check_eq("br_retired", retired, 6);

      // JAL
      fetch_ok(C_JAL);
      mid();
      check_eq("jal_regsel", regsel, REGSEL_PLUS4);
      check_eq("jal_regen", regen, 1);
      check_eq("jal_pcsel", pcsel, PCSEL_ALU);
      tick();

      // LW completing immediately, then writeback
      fetch_ok(C_LW);
      tick(); mem_ready = 1'b1;
      mid();
      check_eq("lw_rd_regsel", regsel, REGSEL_MEM);
      check_eq("lw_rd_regen", regen, 1);
      tick(); mem_ready = 1'b0;
      mid();
      check_eq("lw_wb_rs1sel", rs1sel, RS1SEL_RSD);
      check_eq("lw_wb_regen", regen, 1);
      check_eq("lw_wb_op", op, 10'b010_0000000);
      check_eq("lw_wb_re", re, 0);
      tick();
      mid();
      check_eq("lw_retired", retired, 8);

      // SW interrupted by reset while waiting
      fetch_ok(C_SW);
      tick();
      mid();
      check_eq("sw_we", we, 1);
      check_eq("sw_dsel", dataoutsel, DATAOUTSEL_REG);
      tick(); rst = 1'b1;
      mid();
      check_eq("sw_rst_we", we, 0);
      tick(); rst = 1'b0;
      mid();
      check_eq("sw_rst_retired", retired, 0);
      check_eq("sw_rst_fetch_re", re, 1);
      check_eq("sw_rst_cause", trap_cause, 0);

      // LH at an odd address
      addr_lo = 2'b01;
      fetch_ok(C_LH);
      tick();
      mid();
`ifdef MISALIGN_TRAP_EN
      check_eq("lh_mis_re", re, 0);
      check_eq("lh_mis_trap", trap, 1);
      check_eq("lh_mis_cause", trap_cause, CAUSE_LD_MISALIGN);
`else
      check_eq("lh_mis_re", re, 1);
      check_eq("lh_mis_trap", trap, 0);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Parametrised successor to the single-wait-free RV32I controller: same datapath select interface, but memory accesses use a ready handshake with variable latency and a watchdog timeout. Illegal instructions and memory timeouts produce a recoverable trap instead of a permanent halt, and retired instructions are counted.

Parameters:
MEM_TIMEOUT, 16, max cycles waiting on mem_ready before timeout trap; 0 disables the watchdog
CNT_W, 32, width of retired-instruction counter

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
ir  in  32  instruction register (ir_R_t)
AltB  in  1  ALU compare less-than
AeqB  in  1  ALU compare equal
mem_ready  in  1  memory completes current re/we access this cycle
addr_lo  in  2  ALU result bits [1:0] (optional feature only)
pcsel  out  2  pcsel_t: PC, PLUS4, ALU, TRAP
irsel  out  1  irsel_t
regsel  out  2  regsel_t
regen  out  1  register-file write enable
alusel0  out  1  alusel0_t
alusel1  out  1  alusel1_t
op  out  10  operation_t
re  out  1  memory read request
we  out  1  memory write request
addrsel  out  1  addrsel_t
rs1sel  out  1  rs1sel_t
tmpsel  out  1  tmpsel_t
dataoutsel  out  1  dataoutsel_t
un_signed  out  1  high for BLTU/BGEU
trap  out  1  one-cycle trap pulse
trap_cause  out  4  cause of last trap: 0 none, 2 illegal, 5 mem timeout, 4/6 misaligned load/store
retired  out  CNT_W  retired-instruction count

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. While reset is high, all outputs are forced to 0 combinationally, so no re/we is issued in the reset cycle. After reset: state=FETCH, trap_cause=0, retired=0, wait counter=0. Reset mid-access abandons the access.
- States: FETCH, EXEC, MEM_RD, MEM_WR, WB, TRAP. Outputs are decoded combinationally from state and ir. State, wait counter, trap_cause and retired are registered.
- Memory wait rule: in any state with re or we high, the selects are held stable until mem_ready. pcsel=PC, irsel=IR and regen=0 until the ready cycle. The state-specific effects apply only in the cycle mem_ready=1. The wait counter clears on every state change.
- FETCH: re=1, addrsel=PC. On mem_ready: irsel=MEM, pcsel=PLUS4, go to EXEC.
- EXEC, OP/OPIMM/LUI/AUIPC: regen=1, regsel=ALU. ALU selects and op are as in the existing decode. Go to FETCH.
- EXEC, BRANCH: un_signed and taken logic as today. If taken, pcsel=ALU; otherwise pcsel=PC. alusel0=PC selects the latched instruction address. Go to FETCH.
- EXEC, JAL/JALR: regsel=PLUS4, regen=1, pcsel=ALU. Go to FETCH.
- EXEC, LOAD: go to MEM_RD.
- EXEC, STORE: SW goes to MEM_WR. SB/SH go to MEM_RD, which does the merge read with tmpsel=BYTE/HALF.
- EXEC, any other encoding: go to TRAP with cause 2.
- MEM_RD, LOAD: re=1, addrsel=ALU, op=ADD. On ready: regsel=MEM, regen=1, go to WB.
- MEM_RD, STORE: re=1, addrsel=ALU, op=ADD. On ready go to MEM_WR.
- MEM_WR: we=1, addrsel=ALU, op=ADD. dataoutsel=TMP for SB/SH, REG for SW. On ready go to FETCH.
- WB: rs1sel=RSD, regsel=ALU, regen=1, op={funct3,funct7} for truncation. Go to FETCH.
- Timeout: if MEM_TIMEOUT>0 and the wait counter reaches MEM_TIMEOUT without ready, drop re/we and go to TRAP with cause 5.
- TRAP: pcsel=TRAP, trap=1 for exactly one cycle, trap_cause is registered and held until the next trap. Then go to FETCH. There is no HALT state.
- retired: increments by 1 on every entry to FETCH from EXEC, MEM_WR or WB, never from TRAP. Wraps modulo 2^CNT_W.

Optional Feature:
MISALIGN_TRAP_EN: when defined, entering MEM_RD or MEM_WR with misaligned addr_lo goes to TRAP instead:
- half: addr_lo[0]=1;
- word: addr_lo!=0;
- cause 4 for a load, 6 for a store;
- no memory request is issued.
When undefined, addr_lo is ignored and misaligned accesses proceed.

Decomposition:
- Shared package (existing control package): pcsel_t gains PCSEL_TRAP; new cause_t codes and TRAP_VECTOR constant; state enum stays local.
- Sub-module mem_wait_timer holds the wait counter and timeout compare (parameter MEM_TIMEOUT).

Test Plan:
- ADD x3,x1,x2 with mem_ready after 3 cycles -> re held 3 cycles in FETCH, then irsel=MEM; regen=1 exactly once; retired 0->1.
- LW with mem_ready never asserted, MEM_TIMEOUT=16 -> re low after 16 wait cycles; trap=1 one cycle, trap_cause=5; next state FETCH.
- ir=32'hFFFF_FFFF -> trap pulse, trap_cause=2, retired unchanged; next fetch proceeds normally.
- SB, both accesses ready after 1 cycle -> re with tmpsel=BYTE, then we with dataoutsel=TMP; retired +1.
- BEQ with AeqB=1 then AeqB=0 -> pcsel=ALU, then pcsel=PC; regen=0 both.
- Reset asserted while waiting in MEM_WR -> we=0 that cycle; state=FETCH, retired=0 next cycle. With MISALIGN_TRAP_EN, LH at addr_lo=1 -> cause 4, no re.
